hazard_pipe: RTL and testbench
==============================

HAZARD_PIPE -- requirements
Module: hazard_pipe

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-003 RsD_P  input  5  rs field of instruction in D.
REQ-004 RtD_P  input  5  rt field of instruction in D.
REQ-005 WriteRegD_P  input  5  destination register of instruction in D.
REQ-006 RegWriteD_P  input  1  D instruction writes register file.
REQ-007 T_new_D  input  2  cycles until D instruction's result is available, measured from its entry into E (0..2).
REQ-008 Stall_P  input  1  stall request from hazard unit; D held, bubble inserted into E.
REQ-009 RsE_P, RtE_P  output  5 each  rs/rt of instruction in E.
REQ-010 RtM_P  output  5  rt of instruction in M.
REQ-011 WriteRegE_P, WriteRegM_P, WriteRegW_P  output  5 each  destination register per stage.
REQ-012 RegWriteE_P, RegWriteM_P, RegWriteW_P  output  1 each  write-enable per stage.
REQ-013 T_new_E, T_new_M, T_new_W  output  2 each  remaining Tnew per stage.
REQ-014 Stall_Cnt  output  16  count of stall cycles since reset.

Function
REQ-015 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-016 Normal advance (Stall_P=0, reset=0): E regs SHALL load RsD_P, RtD_P, WriteRegD_P, RegWriteD_P, T_new_D on next edge; latency D->E one cycle.
REQ-017 M regs SHALL load E values each non-reset edge regardless of Stall_P: RtM_P<=RtE_P, WriteRegM_P<=WriteRegE_P, RegWriteM_P<=RegWriteE_P.
REQ-018 W regs SHALL load M values each non-reset edge regardless of Stall_P.
REQ-019 T_new_M SHALL load (T_new_E==0) ? 0 : T_new_E-1; T_new_W SHALL load (T_new_M==0) ? 0 : T_new_M-1; saturating decrement, never wraps to 3.
REQ-020 Stall_P=1: E regs SHALL load bubble -- RsE_P=RtE_P=0, WriteRegE_P=0, RegWriteE_P=0, T_new_E=0; M and W advance per REQ-017..019.
REQ-021 Consecutive stall cycles SHALL each insert one bubble; no D data captured until Stall_P=0.
REQ-022 T_new_D value 3 is illegal input; block SHALL register it unchanged into E and decrement per REQ-019 (no checking).
REQ-023 Instruction with RegWriteD_P=0 or WriteRegD_P=0 SHALL propagate unchanged; suppression of $0 matches is done by hazard unit, not here.
REQ-024 Stall_Cnt SHALL increment by 1 on each non-reset edge with Stall_P=1, saturate at 16'hFFFF, hold otherwise.
REQ-025 Pipeline SHALL be a pure shift: a value entering E appears in M exactly 1 cycle later and in W exactly 2 cycles later, with Tnew reduced by 1 and 2 respectively (floor 0).

Reset
REQ-026 reset=1 at a rising edge SHALL clear every output (all E/M/W fields, Tnew, Stall_Cnt) to 0 on that edge.
REQ-027 reset SHALL take priority over Stall_P and all data inputs; reset asserted mid-stream discards all in-flight stage contents.
REQ-028 First edge after reset deasserts SHALL behave per REQ-016..020 using current inputs.

Verification
REQ-029 Load into pipe: RsD=5, RtD=6, WriteRegD=6, RegWriteD=1, T_new_D=2, Stall=0 for one cycle then bubbles -> cycle1 E: Rs=5,Rt=6,WR=6,Tnew=2; cycle2 M: RtM=6,WR=6,Tnew=1; cycle3 W: WR=6,Tnew=0.
REQ-030 Stall bubble: E holds WR=8,RegWrite=1,Tnew=1; assert Stall for 2 cycles -> E reads all-zero for both cycles, M receives WR=8,Tnew=0 after first, Stall_Cnt=2.
REQ-031 Saturation: T_new_D=0 entered -> T_new_E=0, T_new_M=0, T_new_W=0 (no wrap to 3).
REQ-032 Reset mid-operation: three distinct instructions in E/M/W, reset for 1 cycle with Stall=1 -> all outputs 0, Stall_Cnt=0; next cycle E loads current D inputs.
REQ-033 Counter saturation: hold Stall=1 for 65540 cycles -> Stall_Cnt=16'hFFFF and stays; deassert -> holds 16'hFFFF.
REQ-034 Back-to-back: D instructions with WriteReg 1,2,3 on consecutive cycles, no stall -> at cycle3 WriteRegE/M/W = 3/2/1.

Source files
------------

// File: rtl/hazard_pipe.sv
// E/M/W register pipeline carrying hazard-detection fields (rs/rt, dest, Tnew).
// Stall inserts a bubble into E while M and W keep draining.
module hazard_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RsD_P,
    input  logic [4:0]  RtD_P,
    input  logic [4:0]  WriteRegD_P,
    input  logic        RegWriteD_P,
    input  logic [1:0]  T_new_D,
    input  logic        Stall_P,
    output logic [4:0]  RsE_P,
    output logic [4:0]  RtE_P,
    output logic [4:0]  RtM_P,
    output logic [4:0]  WriteRegE_P,
    output logic [4:0]  WriteRegM_P,
    output logic [4:0]  WriteRegW_P,
    output logic        RegWriteE_P,
    output logic        RegWriteM_P,
    output logic        RegWriteW_P,
    output logic [1:0]  T_new_E,
    output logic [1:0]  T_new_M,
    output logic [1:0]  T_new_W,
    output logic [15:0] Stall_Cnt
);

    logic [1:0] w_tnew_m_nxt;
    logic [1:0] w_tnew_w_nxt;
    logic       w_cnt_sat;

    // Tnew counts down one per stage and floors at zero
    assign w_tnew_m_nxt = (T_new_E == 2'd0) ? 2'd0 : T_new_E - 2'd1;
    assign w_tnew_w_nxt = (T_new_M == 2'd0) ? 2'd0 : T_new_M - 2'd1;
    assign w_cnt_sat    = (Stall_Cnt == 16'hFFFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            RsE_P       <= 5'd0;
            RtE_P       <= 5'd0;
            WriteRegE_P <= 5'd0;
            RegWriteE_P <= 1'b0;
            T_new_E     <= 2'd0;
        end else if (Stall_P) begin
            RsE_P       <= 5'd0;
            RtE_P       <= 5'd0;
            WriteRegE_P <= 5'd0;
            RegWriteE_P <= 1'b0;
            T_new_E     <= 2'd0;
        end else begin
            RsE_P       <= RsD_P;
            RtE_P       <= RtD_P;
            WriteRegE_P <= WriteRegD_P;
            RegWriteE_P <= RegWriteD_P;
            T_new_E     <= T_new_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RtM_P       <= 5'd0;
            WriteRegM_P <= 5'd0;
            RegWriteM_P <= 1'b0;
            T_new_M     <= 2'd0;
            WriteRegW_P <= 5'd0;
            RegWriteW_P <= 1'b0;
            T_new_W     <= 2'd0;
        end else begin
            RtM_P       <= RtE_P;
            WriteRegM_P <= WriteRegE_P;
            RegWriteM_P <= RegWriteE_P;
            T_new_M     <= w_tnew_m_nxt;
            WriteRegW_P <= WriteRegM_P;
            RegWriteW_P <= RegWriteM_P;
            T_new_W     <= w_tnew_w_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Stall_Cnt <= 16'd0;
        end else if (Stall_P && !w_cnt_sat) begin
            Stall_Cnt <= Stall_Cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_pipe.sv
// Scoreboard bench for hazard_pipe: expected stage contents are queued
// when stimulus is driven and compared as they emerge from E, M and W.
module tb_hazard_pipe;

    logic        clk;
    logic        reset;
    logic [4:0]  RsD_P, RtD_P, WriteRegD_P;
    logic        RegWriteD_P;
    logic [1:0]  T_new_D;
    logic        Stall_P;
    logic [4:0]  RsE_P, RtE_P, RtM_P;
    logic [4:0]  WriteRegE_P, WriteRegM_P, WriteRegW_P;
    logic        RegWriteE_P, RegWriteM_P, RegWriteW_P;
    logic [1:0]  T_new_E, T_new_M, T_new_W;
    logic [15:0] Stall_Cnt;

    hazard_pipe dut (
        .clk(clk), .reset(reset),
        .RsD_P(RsD_P), .RtD_P(RtD_P), .WriteRegD_P(WriteRegD_P),
        .RegWriteD_P(RegWriteD_P), .T_new_D(T_new_D), .Stall_P(Stall_P),
        .RsE_P(RsE_P), .RtE_P(RtE_P), .RtM_P(RtM_P),
        .WriteRegE_P(WriteRegE_P), .WriteRegM_P(WriteRegM_P),
        .WriteRegW_P(WriteRegW_P),
        .RegWriteE_P(RegWriteE_P), .RegWriteM_P(RegWriteM_P),
        .RegWriteW_P(RegWriteW_P),
        .T_new_E(T_new_E), .T_new_M(T_new_M), .T_new_W(T_new_W),
        .Stall_Cnt(Stall_Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wr;
        logic       rw;
        logic [1:0] tn;
    } st_t;

    st_t   qE[$], qM[$], qW[$];
    st_t   eE, eM, eW;
    logic [15:0] eCnt;
    int    n_pass = 0;
    int    n_total = 0;

    function automatic logic [1:0] dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic st_t to_m(input st_t e);
        return '{5'd0, e.rt, e.wr, e.rw, dec(e.tn)};
    endfunction

    function automatic st_t to_w(input st_t m);
        return '{5'd0, 5'd0, m.wr, m.rw, dec(m.tn)};
    endfunction

    function automatic st_t act_e();
        return '{RsE_P, RtE_P, WriteRegE_P, RegWriteE_P, T_new_E};
    endfunction

    function automatic st_t act_m();
        return '{5'd0, RtM_P, WriteRegM_P, RegWriteM_P, T_new_M};
    endfunction

    function automatic st_t act_w();
        return '{5'd0, 5'd0, WriteRegW_P, RegWriteW_P, T_new_W};
    endfunction

    task automatic do_reset(input logic stall);
        reset       = 1'b1;
        Stall_P     = stall;
        RsD_P       = 5'd17;
        RtD_P       = 5'd18;
        WriteRegD_P = 5'd19;
        RegWriteD_P = 1'b1;
        T_new_D     = 2'd2;
        @(posedge clk);
        #1;
        reset = 1'b0;
        qE.delete();
        qM.delete();
        qW.delete();
        eE = '0;
        eM = '0;
        eW = '0;
        eCnt = 16'd0;
        qM.push_back('0);
        qW.push_back('0);
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] wr, input logic rw,
                         input logic [1:0] tn, input logic stall);
        st_t ne;
        reset       = 1'b0;
        RsD_P       = rs;
        RtD_P       = rt;
        WriteRegD_P = wr;
        RegWriteD_P = rw;
        T_new_D     = tn;
        Stall_P     = stall;
        ne = stall ? st_t'('0) : st_t'({rs, rt, wr, rw, tn});
        qE.push_back(ne);
        if (stall && eCnt != 16'hFFFF) eCnt = eCnt + 16'd1;
        @(posedge clk);
        #1;
        eE = qE.pop_front();
        eM = qM.pop_front();
        eW = qW.pop_front();
        qM.push_back(to_m(eE));
        qW.push_back(to_w(eM));
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        n_total++;
        if (act_e() !== '0) $display("FAIL reset_E got %h want 0", act_e());
        else n_pass++;
        n_total++;
        if (act_m() !== '0) $display("FAIL reset_M got %h want 0", act_m());
        else n_pass++;
        n_total++;
        if (act_w() !== '0) $display("FAIL reset_W got %h want 0", act_w());
        else n_pass++;
        n_total++;
        if (Stall_Cnt !== 16'd0)
            $display("FAIL reset_cnt got %h want 0", Stall_Cnt);
        else n_pass++;
    endtask

    task automatic test_load();
        do_reset(1'b0);
        drive(5'd5, 5'd6, 5'd6, 1'b1, 2'd2, 1'b0);
        n_total++;
        if (act_e() !== eE || act_e() !== st_t'({5'd5, 5'd6, 5'd6, 1'b1, 2'd2}))
            $display("FAIL load_E got %h want %h", act_e(), eE);
        else n_pass++;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0);
        n_total++;
        if (act_m() !== eM || RtM_P !== 5'd6 || WriteRegM_P !== 5'd6
            || T_new_M !== 2'd1)
            $display("FAIL load_M got %h want %h", act_m(), eM);
        else n_pass++;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0);
        n_total++;
        if (act_w() !== eW || WriteRegW_P !== 5'd6 || T_new_W !== 2'd0)
            $display("FAIL load_W got %h want %h", act_w(), eW);
        else n_pass++;
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        drive(5'd3, 5'd4, 5'd8, 1'b1, 2'd1, 1'b0);
        drive(5'd9, 5'd10, 5'd11, 1'b1, 2'd2, 1'b1);
        n_total++;
        if (act_e() !== '0 || act_e() !== eE)
            $display("FAIL stall1_E got %h want 0", act_e());
        else n_pass++;
        n_total++;
        if (act_m() !== eM || WriteRegM_P !== 5'd8 || T_new_M !== 2'd0)
            $display("FAIL stall1_M got %h want %h", act_m(), eM);
        else n_pass++;
        drive(5'd9, 5'd10, 5'd11, 1'b1, 2'd2, 1'b1);
        n_total++;
        if (act_e() !== '0 || act_w() !== eW)
            $display("FAIL stall2_EW got %h/%h want 0/%h",
                     act_e(), act_w(), eW);
        else n_pass++;
        n_total++;
        if (Stall_Cnt !== eCnt || Stall_Cnt !== 16'd2)
            $display("FAIL stall_cnt got %0d want %0d", Stall_Cnt, eCnt);
        else n_pass++;
        drive(5'd9, 5'd10, 5'd11, 1'b1, 2'd2, 1'b0);
        n_total++;
        if (act_e() !== eE || Stall_Cnt !== 16'd2)
            $display("FAIL stall_release got %h cnt %0d want %h cnt 2",
                     act_e(), Stall_Cnt, eE);
        else n_pass++;
    endtask

    task automatic test_tnew_sat();
        do_reset(1'b0);
        drive(5'd1, 5'd2, 5'd9, 1'b1, 2'd0, 1'b0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'd3, 1'b0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0);
        n_total++;
        if (T_new_W !== 2'd0 || WriteRegW_P !== 5'd9 || act_w() !== eW)
            $display("FAIL tnew0_W got %h want %h", act_w(), eW);
        else n_pass++;
        n_total++;
        if (T_new_M !== 2'd2 || act_m() !== eM)
            $display("FAIL tnew3_M got %h want %h", act_m(), eM);
        else n_pass++;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0);
        n_total++;
        if (T_new_W !== 2'd1 || act_w() !== eW)
            $display("FAIL tnew3_W got %h want %h", act_w(), eW);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        drive(5'd1, 5'd1, 5'd1, 1'b1, 2'd1, 1'b0);
        drive(5'd2, 5'd2, 5'd2, 1'b0, 2'd2, 1'b0);
        drive(5'd3, 5'd3, 5'd3, 1'b1, 2'd0, 1'b0);
        n_total++;
        if (WriteRegE_P !== 5'd3 || WriteRegM_P !== 5'd2
            || WriteRegW_P !== 5'd1)
            $display("FAIL b2b_wr got %0d/%0d/%0d want 3/2/1",
                     WriteRegE_P, WriteRegM_P, WriteRegW_P);
        else n_pass++;
        n_total++;
        if (act_e() !== eE || act_m() !== eM || act_w() !== eW)
            $display("FAIL b2b_all got %h/%h/%h want %h/%h/%h",
                     act_e(), act_m(), act_w(), eE, eM, eW);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(5'd11, 5'd12, 5'd13, 1'b1, 2'd2, 1'b0);
        drive(5'd21, 5'd22, 5'd23, 1'b1, 2'd1, 1'b1);
        drive(5'd24, 5'd25, 5'd26, 1'b1, 2'd2, 1'b0);
        do_reset(1'b1);
        n_total++;
        if (act_e() !== '0 || act_m() !== '0 || act_w() !== '0
            || Stall_Cnt !== 16'd0)
            $display("FAIL reset_mid got %h/%h/%h cnt %0d want all 0",
                     act_e(), act_m(), act_w(), Stall_Cnt);
        else n_pass++;
        drive(5'd7, 5'd14, 5'd28, 1'b0, 2'd1, 1'b0);
        n_total++;
        if (act_e() !== eE || act_m() !== '0)
            $display("FAIL reset_mid_next got %h want %h", act_e(), eE);
        else n_pass++;
    endtask

    task automatic test_cnt_sat();
        do_reset(1'b0);
        for (int i = 0; i < 65540; i++)
            drive(5'd1, 5'd2, 5'd3, 1'b1, 2'd1, 1'b1);
        n_total++;
        if (Stall_Cnt !== 16'hFFFF || Stall_Cnt !== eCnt)
            $display("FAIL cnt_sat got %h want ffff", Stall_Cnt);
        else n_pass++;
        drive(5'd1, 5'd2, 5'd3, 1'b1, 2'd1, 1'b1);
        n_total++;
        if (Stall_Cnt !== 16'hFFFF)
            $display("FAIL cnt_sat_stay got %h want ffff", Stall_Cnt);
        else n_pass++;
        drive(5'd1, 5'd2, 5'd3, 1'b1, 2'd1, 1'b0);
        drive(5'd1, 5'd2, 5'd3, 1'b1, 2'd1, 1'b0);
        n_total++;
        if (Stall_Cnt !== 16'hFFFF || act_e() !== eE)
            $display("FAIL cnt_sat_hold got %h want ffff", Stall_Cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset(1'b0);
        for (int i = 0; i < 60; i++) begin
            drive(5'($urandom), 5'($urandom), 5'($urandom),
                  1'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) == 0));
            n_total++;
            if (act_e() !== eE || act_m() !== eM || act_w() !== eW
                || Stall_Cnt !== eCnt)
                $display("FAIL rand_%0d got %h/%h/%h/%0d want %h/%h/%h/%0d",
                         i, act_e(), act_m(), act_w(), Stall_Cnt,
                         eE, eM, eW, eCnt);
            else n_pass++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        Stall_P     = 1'b0;
        RsD_P       = 5'd0;
        RtD_P       = 5'd0;
        WriteRegD_P = 5'd0;
        RegWriteD_P = 1'b0;
        T_new_D     = 2'd0;
        #1;
        test_reset();
        test_load();
        test_stall();
        test_tnew_sat();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_cnt_sat();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
